control_unit_mc: RTL
====================

Name: control_unit_mc

Overview:
- Multicycle successor to the single-cycle MIPS control decoder.
- A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles for ALU_R, LW, SW, ADDI, BEQ, J and the R-type MULT (funct 0x18).
- Stalls on a memory ready handshake and on a parametrised multi-cycle multiplier.
- Drives the shared-memory datapath: IR, PC, ALU-A/B muxes and register file.

Parameters:
- MULT_LATENCY, 4, cycles the multiplier needs after mult_start; legal range 1..255.
- ENABLE_MULT, 1, 0 means MULT is treated as an illegal instruction.

Ports:
- clk  in  1  system clock.
- arst  in  1  asynchronous reset, active-high.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory completed the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load IR.
- mem_2_reg  out  1  writeback selects MDR.
- reg_dst  out  1  write register is rd (1) or rt (0).
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  0 = B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
- alu_op  out  2  0 = ADD, 1 = SUB, 2 = R-type (funct decodes).
- mult_start  out  1  one-cycle multiplier launch.
- illegal_op  out  1  one-cycle flag for an unsupported opcode/funct.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.

Behaviour:
- States: RESET, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, MULT_EXEC, MULT_WAIT.
- Outputs are a pure function of state, except FETCH's ir_write/pc_write, which are gated by mem_ready.
- Any output not listed for a state is 0.
- arst high: state = RESET, mult counter = 0, all outputs 0, taking effect immediately. Reset mid-instruction abandons it with no further writes.
- RESET: all outputs 0 -> FETCH next cycle.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0.
  - ir_write = pc_write = mem_ready.
  - Hold while mem_ready=0; mem_ready=1 -> DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=ADD.
  - LW/SW -> MEM_ADDR; ADDI -> EXEC_I; BEQ -> BRANCH; J -> JUMP.
  - ALU_R with funct 0x18 and ENABLE_MULT=1 -> MULT_EXEC; other ALU_R -> EXEC_R.
  - Any other opcode (or MULT with ENABLE_MULT=0): illegal_op=1, instr_done=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD; LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_2_reg=1, reg_dst=0, instr_done=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready, then instr_done=1 in the same cycle -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=R-type -> R_WB.
- R_WB: reg_write=1, reg_dst=1, instr_done=1 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=ADD -> I_WB.
- I_WB: reg_write=1, reg_dst=0, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_write_cond=1, pc_source=1, instr_done=1 -> FETCH.
- JUMP: pc_write=1, pc_source=2, instr_done=1 -> FETCH.
- MULT_EXEC:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=R-type, mult_start=1.
  - Counter loads MULT_LATENCY-1.
  - MULT_LATENCY=1 -> R_WB; otherwise -> MULT_WAIT.
- MULT_WAIT: counter decrements each cycle; when counter==1 -> R_WB. The MULT instruction therefore spends exactly MULT_LATENCY cycles from MULT_EXEC entry to R_WB entry.
- Counter width: CNT_W = $clog2(MULT_LATENCY+1). The counter never underflows; it is held at 0 outside MULT states.
- mem_read and mem_write are never both 1.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- Instruction latency with zero-wait memory: R/ADDI 4, LW 5, SW 4, BEQ 3, J 3, MULT 3+MULT_LATENCY cycles (FETCH through writeback).

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants: ALU_R 0x00, J 0x02, BEQ 0x04, ADDI 0x08, LW 0x23, SW 0x2B;
  - FUNCT_MULT 0x18;
  - alu_op encodings: ADD 0, SUB 1, R-type 2;
  - the state enum;
  - pc_source/alu_src_b encodings.
- One sub-module, ctrl_wait_counter (loadable down-counter, parametrised width, terminal flag), used for the MULT wait.

Test Plan:
- Reset asserted mid-MEM_RD with mem_ready=0 -> all outputs 0 immediately; after release, RESET for one cycle, then FETCH with mem_read=1.
- ADDI (opcode 0x08), mem_ready tied 1 -> states FETCH, DECODE, EXEC_I, I_WB; reg_write=1 with reg_dst=0 only in cycle 4; instr_done pulses once.
- LW with mem_ready low for 3 cycles in MEM_RD -> mem_read/i_or_d held 4 cycles; single reg_write with mem_2_reg=1; total 8 cycles.
- MULT (opcode 0, funct 0x18), MULT_LATENCY=4 -> mult_start high exactly 1 cycle; R_WB entered 4 cycles after MULT_EXEC. Repeat with MULT_LATENCY=1: MULT_EXEC -> R_WB directly.
- Opcode 0x3F -> illegal_op and instr_done for 1 cycle in DECODE, no reg_write/mem_write, return to FETCH. MULT with ENABLE_MULT=0 behaves the same.
- BEQ then J back-to-back -> pc_write_cond=1, pc_source=1 in BRANCH; pc_write=1, pc_source=2 in JUMP; 3 cycles each.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// opcodes, mux selects, ALU ops, FSM states and the control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_ALU_R = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_MULT = 6'h18;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_RTYPE = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } src_b_e;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_BRANCH,
    S_JUMP,
    S_MULT_EXEC,
    S_MULT_WAIT
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_2_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mult_start;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/control_unit_mc_wait_counter.sv
// Loadable down-counter used to time the multi-cycle multiplier.
// Saturates at zero and clears whenever it is not enabled.
module ctrl_wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         term
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!en) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign term = (count == W'(1));

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle MIPS control FSM (Moore) with memory-ready
// stalls and a parametrised multiplier wait.
module control_unit_mc
  import mips_ctrl_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter bit ENABLE_MULT  = 1'b1
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_2_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       mult_start,
  output logic       illegal_op,
  output logic       instr_done
);

  localparam int CNT_W = $clog2(MULT_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(MULT_LATENCY - 1);

  state_e state;
  state_e state_nxt;
  ctrl_t  c;

  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt;
  logic             cnt_term;

  logic is_mem;
  logic is_addi;
  logic is_beq;
  logic is_j;
  logic is_mult;
  logic is_r;

  assign is_mem  = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_addi = (opcode == OP_ADDI);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign is_mult = (opcode == OP_ALU_R) &&
                   (funct == FUNCT_MULT) && ENABLE_MULT;
  // MULT is never plain R-type, so a disabled MULT is illegal
  assign is_r    = (opcode == OP_ALU_R) &&
                   (funct != FUNCT_MULT);

  ctrl_wait_counter #(
    .W (CNT_W)
  ) u_wait (
    .clk      (clk),
    .arst     (arst),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .en       (cnt_en),
    .count    (cnt),
    .term     (cnt_term)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= S_RESET;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    c         = '0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    unique case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PC_ALU;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALU_ADD;
        unique case (1'b1)
          is_mem:  state_nxt = S_MEM_ADDR;
          is_addi: state_nxt = S_EXEC_I;
          is_beq:  state_nxt = S_BRANCH;
          is_j:    state_nxt = S_JUMP;
          is_mult: state_nxt = S_MULT_EXEC;
          is_r:    state_nxt = S_EXEC_R;
          default: begin
            c.illegal_op = 1'b1;
            c.instr_done = 1'b1;
            state_nxt    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
        state_nxt   = (opcode == OP_SW) ? S_MEM_WR
                                        : S_MEM_RD;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_2_reg  = 1'b1;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        if (mem_ready) begin
          c.instr_done = 1'b1;
          state_nxt    = S_FETCH;
        end
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALU_RTYPE;
        state_nxt   = S_R_WB;
      end
      S_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
        state_nxt   = S_I_WB;
      end
      S_I_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PC_ALUOUT;
        c.instr_done    = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PC_JUMP;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MULT_EXEC: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_B;
        c.alu_op     = ALU_RTYPE;
        c.mult_start = 1'b1;
        cnt_load     = 1'b1;
        state_nxt    = (MULT_LATENCY == 1) ? S_R_WB
                                           : S_MULT_WAIT;
      end
      S_MULT_WAIT: begin
        cnt_en = 1'b1;
        if (cnt_term) state_nxt = S_R_WB;
      end
      default: state_nxt = S_RESET;
    endcase
  end

  assign pc_write      = c.pc_write;
  assign pc_write_cond = c.pc_write_cond;
  assign pc_source     = c.pc_source;
  assign i_or_d        = c.i_or_d;
  assign mem_read      = c.mem_read;
  assign mem_write     = c.mem_write;
  assign ir_write      = c.ir_write;
  assign mem_2_reg     = c.mem_2_reg;
  assign reg_dst       = c.reg_dst;
  assign reg_write     = c.reg_write;
  assign alu_src_a     = c.alu_src_a;
  assign alu_src_b     = c.alu_src_b;
  assign alu_op        = c.alu_op;
  assign mult_start    = c.mult_start;
  assign illegal_op    = c.illegal_op;
  assign instr_done    = c.instr_done;

endmodule
